// File: rtl/ram_arbiter_if.sv
// Requester-side command/response bundle for the two-port RAM arbiter.
interface ram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    // Requester side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-requester controller for a single-port synchronous RAM with a
// shared bidirectional data bus; sequences the RAM clear after reset.
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic                  ram_rst,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {INIT, IDLE, WR, RD, RDCAP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_sel;
    logic                  pick1;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  gnt0_d, gnt1_d;
    logic                  rvalid0_d, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
    logic                  ram_we_d, ram_rst_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;

    // Bus is driven only while the registered write enable is high; RAM owns it otherwise.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_rst     <= 1'b1;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            bus.gnt0    <= gnt0_d;
            bus.gnt1    <= gnt1_d;
            bus.rvalid0 <= rvalid0_d;
            bus.rvalid1 <= rvalid1_d;
            bus.rdata0  <= rdata0_d;
            bus.rdata1  <= rdata1_d;
            ram_we      <= ram_we_d;
            ram_addr    <= ram_addr_d;
            ram_rst     <= ram_rst_d;
        end
    end

    // Next state, arbitration and next output values
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = bus.rdata0;
        rdata1_d   = bus.rdata1;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr;
        ram_rst_d  = 1'b0;

        // Lone requester wins; on contention the port that did not win last time wins.
        pick1   = bus.req1 && (!bus.req0 || !last_q);
        cmd_sel = pick1 ? cmd_t'{bus.we1, bus.addr1, bus.wdata1}
                        : cmd_t'{bus.we0, bus.addr0, bus.wdata0};

        case (state_q)
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d    = pick1;
                    last_d     = pick1;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    wdata_d    = cmd_sel.wdata;
                    ram_addr_d = cmd_sel.addr;
                    ram_we_d   = cmd_sel.we;
                    state_d    = cmd_sel.we ? WR : RD;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                state_d = RDCAP;
            end
            RDCAP: begin
                state_d = IDLE;
                if (owner_q) begin
                    rdata1_d  = ram_data;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = ram_data;
                    rvalid0_d = 1'b1;
                end
            end
            default: begin
                state_d   = INIT;
                ram_rst_d = 1'b1;
            end
        endcase
    end

endmodule
